// File: rtl/mem_read_scheduler.sv
// Per-event read scheduler: latches per-memory entry counts on start, then issues one
// read per cycle round-robin across non-empty memories until drained or out of budget.
module mem_read_scheduler #(
   parameter int unsigned NMEM  = 7,
   parameter int unsigned AW    = 6,
   parameter int unsigned MAXRD = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [NMEM*AW-1:0] number_in,
   input  logic               stall,
   output logic [AW-1:0]      read_add,
   output logic [NMEM-1:0]    sel,
   output logic [3:0]         src,
   output logic               valid,
   output logic               busy,
   output logic               done,
   output logic               truncated
);

   localparam int unsigned IW = $clog2(NMEM);

   typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q [NMEM];
   logic [AW-1:0]   cnt_d [NMEM];
   logic [7:0]      budget_q, budget_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [AW-1:0]   read_add_q, read_add_d;
   logic [NMEM-1:0] sel_q, sel_d;
   logic [3:0]      src_q, src_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            truncated_q, truncated_d;

   logic            any_left;
   logic            found;
   logic [IW-1:0]   gnt;
   logic [IW-1:0]   scan;

   // Round-robin search starting just after the last granted memory.
   always_comb begin
      any_left = 1'b0;
      found    = 1'b0;
      gnt      = '0;
      scan     = '0;
      for (int i = 0; i < NMEM; i++) begin
         if (cnt_q[i] != '0) any_left = 1'b1;
      end
      for (int unsigned k = 1; k <= NMEM; k++) begin
         scan = IW'((32'(rr_q) + k) % NMEM);
         if (!found && cnt_q[scan] != '0) begin
            found = 1'b1;
            gnt   = scan;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      budget_d    = budget_q;
      rr_d        = rr_q;
      read_add_d  = read_add_q;
      src_d       = src_q;
      sel_d       = '0;
      valid_d     = 1'b0;
      done_d      = 1'b0;
      truncated_d = 1'b0;

      case (state_q)
         StIdle: ;
         StRead: begin
            if (start) begin
               // Aborted event still reports its completion.
               done_d      = 1'b1;
               truncated_d = any_left;
            end else begin
               budget_d = budget_q - 8'd1;
               if (!any_left) begin
                  state_d = StDone;
               end else begin
                  if (!stall && found) begin
                     read_add_d = cnt_q[gnt] - AW'(1);
                     sel_d      = NMEM'(1) << gnt;
                     src_d      = 4'(gnt);
                     valid_d    = 1'b1;
                     cnt_d[gnt] = cnt_q[gnt] - AW'(1);
                     rr_d       = gnt;
                  end
                  if (budget_q == 8'd1) state_d = StDone;
               end
            end
         end
         StDone: begin
            done_d      = 1'b1;
            truncated_d = any_left;
            state_d     = StIdle;
            for (int i = 0; i < NMEM; i++) cnt_d[i] = '0;
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         for (int i = 0; i < NMEM; i++) cnt_d[i] = number_in[i*AW +: AW];
         budget_d = 8'(MAXRD);
         rr_d     = IW'(NMEM - 1);
         state_d  = StRead;
         sel_d    = '0;
         valid_d  = 1'b0;
      end

      busy_d = (state_d == StRead);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         for (int i = 0; i < NMEM; i++) cnt_q[i] <= '0;
         budget_q    <= '0;
         rr_q        <= IW'(NMEM - 1);
         read_add_q  <= '0;
         sel_q       <= '0;
         src_q       <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         truncated_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         budget_q    <= budget_d;
         rr_q        <= rr_d;
         read_add_q  <= read_add_d;
         sel_q       <= sel_d;
         src_q       <= src_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         truncated_q <= truncated_d;
      end
   end

   assign read_add  = read_add_q;
   assign sel       = sel_q;
   assign src       = src_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign truncated = truncated_q;

endmodule

// File: tb/tb_mem_read_scheduler.sv
// Directed bench for mem_read_scheduler: one DUT with MAXRD=64 and a MAXRD=5 twin
// sharing the same stimulus for the budget-truncation case.
module tb_mem_read_scheduler;

   logic        clk = 1'b0;
   logic        reset, start, stall;
   logic [41:0] number_in;

   logic [5:0]  read_add, read_add5;
   logic [6:0]  sel, sel5;
   logic [3:0]  src, src5;
   logic        valid, busy, done, truncated;
   logic        valid5, busy5, done5, truncated5;

   int n_tests = 0;
   int n_fail  = 0;

   int q_src[$];
   int q_addr[$];
   int q_cyc[$];
   int done_cyc;
   logic got_trunc, busy1;
   int n5;
   logic done5_seen, trunc5;

   always #5 clk = ~clk;

   mem_read_scheduler #(.NMEM(7), .AW(6), .MAXRD(64)) u_dut (
      .clk(clk), .reset(reset), .start(start), .number_in(number_in), .stall(stall),
      .read_add(read_add), .sel(sel), .src(src), .valid(valid), .busy(busy),
      .done(done), .truncated(truncated)
   );

   mem_read_scheduler #(.NMEM(7), .AW(6), .MAXRD(5)) u_dut5 (
      .clk(clk), .reset(reset), .start(start), .number_in(number_in), .stall(stall),
      .read_add(read_add5), .sel(sel5), .src(src5), .valid(valid5), .busy(busy5),
      .done(done5), .truncated(truncated5)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [41:0] pack(input int c[7]);
      logic [41:0] p;
      p = '0;
      for (int i = 0; i < 7; i++) p[i*6 +: 6] = 6'(c[i]);
      return p;
   endfunction

   // Steps from cycle c_first until done, recording every read and the twin's results.
   task automatic capture(input int c_first, input int limit, input int st_from,
                          input int st_to);
      q_src.delete();
      q_addr.delete();
      q_cyc.delete();
      done_cyc   = -1;
      got_trunc  = 1'b0;
      busy1      = 1'b0;
      n5         = 0;
      done5_seen = 1'b0;
      trunc5     = 1'b0;
      for (int c = c_first; c <= limit && done_cyc < 0; c++) begin
         tick();
         start = 1'b0;
         stall = (c >= st_from && c <= st_to);
         if (c == 1) busy1 = busy;
         if (valid) begin
            q_src.push_back(int'(src));
            q_addr.push_back(int'(read_add));
            q_cyc.push_back(c);
            check_eq("sel_onehot", 32'(sel), 32'd1 << src);
         end
         if (valid5) n5++;
         if (done5 && !done5_seen) begin
            done5_seen = 1'b1;
            trunc5     = truncated5;
         end
         if (done) begin
            done_cyc  = c;
            got_trunc = truncated;
         end
      end
      stall = 1'b0;
      check_eq("done_seen", 32'(done_cyc >= 0), 32'd1);
   endtask

   task automatic check_reads(input string tag, input int es[$], input int ea[$]);
      check_eq({tag, "_count"}, 32'(q_src.size()), 32'(es.size()));
      for (int i = 0; i < es.size() && i < q_src.size(); i++) begin
         check_eq({tag, "_src"}, 32'(q_src[i]), 32'(es[i]));
         check_eq({tag, "_addr"}, 32'(q_addr[i]), 32'(ea[i]));
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_read_add"}, 32'(read_add), 32'd0);
      check_eq({tag, "_sel"}, 32'(sel), 32'd0);
      check_eq({tag, "_src"}, 32'(src), 32'd0);
      check_eq({tag, "_valid"}, 32'(valid), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_trunc"}, 32'(truncated), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int es[$];
      int ea[$];

      reset = 1'b0; start = 1'b0; stall = 1'b0; number_in = '0;
      tick();
      tick();
      check_idle_outputs("reset");
      reset = 1'b1;
      tick();

      // Mixed counts: m0=2, m2=1.
      number_in = pack('{2, 0, 1, 0, 0, 0, 0});
      start = 1'b1;
      capture(1, 40, -1, -1);
      check_eq("t1_busy_c1", 32'(busy1), 32'd1);
      check_reads("t1", '{0, 2, 0}, '{1, 0, 0});
      check_eq("t1_cyc0", 32'(q_cyc.size() > 0 ? q_cyc[0] : -1), 32'd2);
      check_eq("t1_cyc2", 32'(q_cyc.size() > 2 ? q_cyc[2] : -1), 32'd4);
      check_eq("t1_done_cyc", 32'(done_cyc), 32'd6);
      check_eq("t1_trunc", 32'(got_trunc), 32'd0);

      // All counts zero.
      number_in = '0;
      start = 1'b1;
      capture(1, 20, -1, -1);
      check_eq("t0_busy_c1", 32'(busy1), 32'd1);
      check_eq("t0_reads", 32'(q_src.size()), 32'd0);
      check_eq("t0_done_cyc", 32'(done_cyc), 32'd3);
      check_eq("t0_trunc", 32'(got_trunc), 32'd0);

      // All seven memories with 3 entries.
      number_in = pack('{3, 3, 3, 3, 3, 3, 3});
      start = 1'b1;
      capture(1, 60, -1, -1);
      es.delete(); ea.delete();
      for (int k = 0; k < 21; k++) begin
         es.push_back(k % 7);
         ea.push_back(2 - k / 7);
      end
      check_reads("t2", es, ea);
      check_eq("t2_trunc", 32'(got_trunc), 32'd0);

      // m3=63 fits the budget exactly.
      number_in = pack('{0, 0, 0, 63, 0, 0, 0});
      start = 1'b1;
      capture(1, 120, -1, -1);
      es.delete(); ea.delete();
      for (int k = 0; k < 63; k++) begin
         es.push_back(3);
         ea.push_back(62 - k);
      end
      check_reads("t3a", es, ea);
      check_eq("t3a_done_cyc", 32'(done_cyc), 32'd66);
      check_eq("t3a_trunc", 32'(got_trunc), 32'd0);

      // m3=63, m4=5 exceeds the budget.
      number_in = pack('{0, 0, 0, 63, 5, 0, 0});
      start = 1'b1;
      capture(1, 120, -1, -1);
      check_eq("t3b_count", 32'(q_src.size()), 32'd64);
      check_eq("t3b_src0", 32'(q_src.size() > 3 ? q_src[0] : -1), 32'd3);
      check_eq("t3b_src1", 32'(q_src.size() > 3 ? q_src[1] : -1), 32'd4);
      check_eq("t3b_src2", 32'(q_src.size() > 3 ? q_src[2] : -1), 32'd3);
      check_eq("t3b_done_cyc", 32'(done_cyc), 32'd66);
      check_eq("t3b_trunc", 32'(got_trunc), 32'd1);

      // m1=4 with stall in cycles 3..5; the MAXRD=5 twin gets only two reads.
      number_in = pack('{0, 4, 0, 0, 0, 0, 0});
      start = 1'b1;
      capture(1, 40, 3, 5);
      check_reads("t4", '{1, 1, 1, 1}, '{3, 2, 1, 0});
      check_eq("t4_cyc1", 32'(q_cyc.size() > 3 ? q_cyc[1] : -1), 32'd3);
      check_eq("t4_cyc2", 32'(q_cyc.size() > 3 ? q_cyc[2] : -1), 32'd7);
      check_eq("t4_trunc", 32'(got_trunc), 32'd0);
      check_eq("t4_m5_reads", 32'(n5), 32'd2);
      check_eq("t4_m5_done", 32'(done5_seen), 32'd1);
      check_eq("t4_m5_trunc", 32'(trunc5), 32'd1);

      // Restart mid-event with 10 entries left in m2.
      number_in = pack('{0, 0, 15, 0, 0, 0, 0});
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      check_eq("t5_valid_pre", 32'(valid), 32'd1);
      check_eq("t5_addr_pre", 32'(read_add), 32'd10);
      number_in = pack('{2, 0, 0, 0, 0, 0, 1});
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("t5_abort_done", 32'(done), 32'd1);
      check_eq("t5_abort_trunc", 32'(truncated), 32'd1);
      check_eq("t5_abort_valid", 32'(valid), 32'd0);
      check_eq("t5_abort_busy", 32'(busy), 32'd1);
      capture(2, 40, -1, -1);
      check_reads("t5", '{0, 6, 0}, '{1, 0, 0});
      check_eq("t5_cyc0", 32'(q_cyc.size() > 0 ? q_cyc[0] : -1), 32'd2);
      check_eq("t5_done_cyc", 32'(done_cyc), 32'd6);
      check_eq("t5_trunc", 32'(got_trunc), 32'd0);

      // Reset while reading; a coincident start must be ignored.
      number_in = pack('{5, 0, 0, 0, 0, 0, 0});
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_eq("t6_valid_pre", 32'(valid), 32'd1);
      check_eq("t6_addr_pre", 32'(read_add), 32'd3);
      reset = 1'b0;
      start = 1'b1;
      tick();
      check_idle_outputs("t6_rst");
      reset = 1'b1;
      start = 1'b0;
      tick();
      tick();
      check_eq("t6_post_busy", 32'(busy), 32'd0);
      check_eq("t6_post_valid", 32'(valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
